// File: rtl/rf_pkg.sv
// Shared types and default sizing for the SIMD vector/scalar register file.
package rf_pkg;

    localparam int DEF_LANES = 16;
    localparam int DEF_W     = 32;
    localparam int DEF_NVREG = 16;
    localparam int DEF_NSREG = 16;

    typedef enum logic [1:0] {
        RS_VEC   = 2'b00,
        RS_SCA   = 2'b01,
        RS_BCAST = 2'b10,
        RS_RSVD  = 2'b11
    } rsel_t;

    typedef logic [DEF_W-1:0] lane_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for pending vector/scalar writebacks, with set-over-clear
// priority, a one-cycle conflict pulse and two post-update lookup ports.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NVREG = DEF_NVREG,
    parameter int NSREG = DEF_NSREG,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          wsel_v,
    input  logic [AW-1:0] wa,
    input  logic          sb_set,
    input  logic          sb_set_v,
    input  logic [AW-1:0] sb_idx,
    input  logic          lk1_v,
    input  logic [AW-1:0] lk1_idx,
    output logic          lk1_busy,
    input  logic          lk2_v,
    input  logic [AW-1:0] lk2_idx,
    output logic          lk2_busy,
    output logic          sb_conflict
);

    logic [NVREG-1:0] busy_v, busy_v_nxt;
    logic [NSREG-1:0] busy_s, busy_s_nxt;
    logic             conflict_nxt;

    function automatic logic v_ok(input logic [AW-1:0] idx);
        return int'(idx) < NVREG;
    endfunction

    // The PC alias (top scalar index) has no busy bit, so it can never be busy.
    function automatic logic s_ok(input logic [AW-1:0] idx);
        return int'(idx) < NSREG - 1;
    endfunction

    always_comb begin
        busy_v_nxt   = busy_v;
        busy_s_nxt   = busy_s;
        conflict_nxt = 1'b0;
        if (we && wsel_v && v_ok(wa))
            busy_v_nxt[wa] = 1'b0;
        if (we && !wsel_v && s_ok(wa))
            busy_s_nxt[wa] = 1'b0;
        // Set is applied after clear so a new pending op wins over a retiring write.
        if (sb_set && sb_set_v && v_ok(sb_idx)) begin
            conflict_nxt       = busy_v[sb_idx];
            busy_v_nxt[sb_idx] = 1'b1;
        end
        if (sb_set && !sb_set_v && s_ok(sb_idx)) begin
            conflict_nxt       = busy_s[sb_idx];
            busy_s_nxt[sb_idx] = 1'b1;
        end
    end

    always_comb begin
        lk1_busy = 1'b0;
        lk2_busy = 1'b0;
        if (lk1_v) begin
            if (v_ok(lk1_idx)) lk1_busy = busy_v_nxt[lk1_idx];
        end else if (s_ok(lk1_idx)) begin
            lk1_busy = busy_s_nxt[lk1_idx];
        end
        if (lk2_v) begin
            if (v_ok(lk2_idx)) lk2_busy = busy_v_nxt[lk2_idx];
        end else if (s_ok(lk2_idx)) begin
            lk2_busy = busy_s_nxt[lk2_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_v      <= '0;
            busy_s      <= '0;
            sb_conflict <= 1'b0;
        end else begin
            busy_v      <= busy_v_nxt;
            busy_s      <= busy_s_nxt;
            sb_conflict <= conflict_nxt;
        end
    end

endmodule

// File: rtl/vec_regfile_v2.sv
// Vector/scalar register file with two registered read ports, write-first
// forwarding, lane-masked vector writes, a PC alias and a busy scoreboard.
module vec_regfile_v2
    import rf_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int W     = DEF_W,
    parameter int NVREG = DEF_NVREG,
    parameter int NSREG = DEF_NSREG,
    parameter int AW    = $clog2((NVREG > NSREG) ? NVREG : NSREG)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [W-1:0]              pc,
    input  logic [AW-1:0]             ra1,
    input  logic [AW-1:0]             ra2,
    input  logic [1:0]                rsel1,
    input  logic [1:0]                rsel2,
    input  logic                      we,
    input  logic                      wsel_v,
    input  logic [AW-1:0]             wa,
    input  logic [LANES-1:0][W-1:0]   wd,
    input  logic [LANES-1:0]          wmask,
    input  logic                      sb_set,
    input  logic                      sb_set_v,
    input  logic [AW-1:0]             sb_idx,
    output logic [LANES-1:0][W-1:0]   rd1,
    output logic [LANES-1:0][W-1:0]   rd2,
    output logic                      busy1,
    output logic                      busy2,
    output logic                      sb_conflict
);

    logic [LANES-1:0][W-1:0] vreg [NVREG];
    logic [W-1:0]            sreg [NSREG];

    logic                    vwr_ok, swr_ok;
    logic [AW-1:0]           ra_p0   [2];
    logic [1:0]              rsel_p0 [2];
    logic [LANES-1:0][W-1:0] rd_p0   [2];
    logic                    lk_busy [2];

    assign vwr_ok     = we && wsel_v && (int'(wa) < NVREG);
    assign swr_ok     = we && !wsel_v && (int'(wa) < NSREG - 1);
    assign ra_p0[0]   = ra1;
    assign ra_p0[1]   = ra2;
    assign rsel_p0[0] = rsel1;
    assign rsel_p0[1] = rsel2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NVREG; r++) vreg[r] <= '0;
            for (int r = 0; r < NSREG; r++) sreg[r] <= '0;
        end else begin
            if (vwr_ok) begin
                for (int l = 0; l < LANES; l++)
                    if (wmask[l]) vreg[wa][l] <= wd[l];
            end
            if (swr_ok) sreg[wa] <= wd[LANES-1];
        end
    end

    always_comb begin : rd_mux
        logic [LANES-1:0][W-1:0] vec_val;
        logic [W-1:0]            sca_val;
        for (int p = 0; p < 2; p++) begin
            vec_val  = '0;
            sca_val  = '0;
            rd_p0[p] = '0;
            if (int'(ra_p0[p]) < NVREG) begin
                for (int l = 0; l < LANES; l++) begin
                    if (vwr_ok && wa == ra_p0[p] && wmask[l]) vec_val[l] = wd[l];
                    else                                      vec_val[l] = vreg[ra_p0[p]][l];
                end
            end
            // Alias is checked first; scalar writes to it never forward.
            if (int'(ra_p0[p]) == NSREG - 1)            sca_val = pc;
            else if (swr_ok && wa == ra_p0[p])          sca_val = wd[LANES-1];
            else if (int'(ra_p0[p]) < NSREG)            sca_val = sreg[ra_p0[p]];
            case (rsel_t'(rsel_p0[p]))
                RS_VEC:   rd_p0[p] = vec_val;
                RS_SCA:   rd_p0[p][LANES-1] = sca_val;
                RS_BCAST: for (int l = 0; l < LANES; l++) rd_p0[p][l] = sca_val;
                default:  rd_p0[p] = '0;
            endcase
        end
    end

    rf_scoreboard #(
        .NVREG (NVREG),
        .NSREG (NSREG),
        .AW    (AW)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .wsel_v      (wsel_v),
        .wa          (wa),
        .sb_set      (sb_set),
        .sb_set_v    (sb_set_v),
        .sb_idx      (sb_idx),
        .lk1_v       (rsel1 == RS_VEC),
        .lk1_idx     (ra1),
        .lk1_busy    (lk_busy[0]),
        .lk2_v       (rsel2 == RS_VEC),
        .lk2_idx     (ra2),
        .lk2_busy    (lk_busy[1]),
        .sb_conflict (sb_conflict)
    );

    // p0 -> output register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1   <= '0;
            rd2   <= '0;
            busy1 <= 1'b0;
            busy2 <= 1'b0;
        end else begin
            rd1   <= rd_p0[0];
            rd2   <= rd_p0[1];
            busy1 <= lk_busy[0] && (rsel1 != RS_RSVD);
            busy2 <= lk_busy[1] && (rsel2 != RS_RSVD);
        end
    end

endmodule

// File: tb/tb_vec_regfile_v2.sv
// Directed self-checking bench for vec_regfile_v2 with hand-computed expectations.
module tb_vec_regfile_v2;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       pc;
    logic [3:0]        ra1, ra2, wa, sb_idx;
    logic [1:0]        rsel1, rsel2;
    logic              we, wsel_v, sb_set, sb_set_v;
    logic [15:0][31:0] wd, rd1, rd2, exp_v;
    logic [15:0]       wmask;
    logic              busy1, busy2, sb_conflict;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    vec_regfile_v2 dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .ra1         (ra1),
        .ra2         (ra2),
        .rsel1       (rsel1),
        .rsel2       (rsel2),
        .we          (we),
        .wsel_v      (wsel_v),
        .wa          (wa),
        .wd          (wd),
        .wmask       (wmask),
        .sb_set      (sb_set),
        .sb_set_v    (sb_set_v),
        .sb_idx      (sb_idx),
        .rd1         (rd1),
        .rd2         (rd2),
        .busy1       (busy1),
        .busy2       (busy2),
        .sb_conflict (sb_conflict)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got=%h want=%h", tag, obs, exp);
    endtask

    function automatic logic [511:0] lane_only(input int l, input logic [31:0] v);
        logic [15:0][31:0] r;
        r    = '0;
        r[l] = v;
        return r;
    endfunction

    function automatic logic [511:0] bcast(input logic [31:0] v);
        logic [15:0][31:0] r;
        for (int l = 0; l < 16; l++) r[l] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; pc = '0; ra1 = '0; ra2 = '0; rsel1 = 2'b00; rsel2 = 2'b00;
        we = 1'b0; wsel_v = 1'b0; wa = '0; wd = '0; wmask = '0;
        sb_set = 1'b0; sb_set_v = 1'b0; sb_idx = '0;
        tick(); tick();
        chk("rst_rd1", rd1, '0);
        chk("rst_busy1", {511'b0, busy1}, '0);
        chk("rst_conflict", {511'b0, sb_conflict}, '0);
        rst = 1'b1;

        // reset contents
        ra1 = 4'd3; rsel1 = 2'b00; ra2 = 4'd2; rsel2 = 2'b01;
        tick();
        chk("v3_zero", rd1, '0);
        chk("s2_zero", rd2, '0);
        chk("v3_busy", {511'b0, busy1}, '0);
        ra1 = 4'd15; rsel1 = 2'b01; pc = 32'h100;
        tick();
        chk("pc_alias", rd1, lane_only(15, 32'h100));

        // masked vector write, forwarded then from array
        we = 1'b1; wsel_v = 1'b1; wa = 4'd5; wd = bcast(32'hA5); wmask = 16'h00FF;
        ra1 = 4'd5; rsel1 = 2'b00;
        exp_v = '0;
        for (int l = 0; l < 8; l++) exp_v[l] = 32'hA5;
        tick();
        chk("v5_fwd", rd1, exp_v);
        we = 1'b0;
        tick();
        chk("v5_array", rd1, exp_v);

        // scalar write, then broadcast and scalar reads
        we = 1'b1; wsel_v = 1'b0; wa = 4'd4; wd = lane_only(15, 32'd7);
        tick();
        we = 1'b0; ra1 = 4'd4; rsel1 = 2'b10; ra2 = 4'd4; rsel2 = 2'b01;
        tick();
        chk("s4_bcast", rd1, bcast(32'd7));
        chk("s4_sca", rd2, lane_only(15, 32'd7));
        ra1 = 4'd5; rsel1 = 2'b11;
        tick();
        chk("rsvd_zero", rd1, '0);

        // write to PC alias is dropped
        we = 1'b1; wsel_v = 1'b0; wa = 4'd15; wd = lane_only(15, 32'd9);
        ra1 = 4'd15; rsel1 = 2'b01; pc = 32'h200;
        tick();
        chk("alias_fwd", rd1, lane_only(15, 32'h200));
        we = 1'b0;
        tick();
        chk("alias_arr", rd1, lane_only(15, 32'h200));

        // scoreboard set / conflict / clear
        sb_set = 1'b1; sb_set_v = 1'b1; sb_idx = 4'd2;
        ra1 = 4'd2; rsel1 = 2'b00; ra2 = 4'd2; rsel2 = 2'b01;
        tick();
        chk("v2_busy_set", {511'b0, busy1}, 512'd1);
        chk("s2_not_busy", {511'b0, busy2}, '0);
        chk("no_conflict", {511'b0, sb_conflict}, '0);
        sb_set = 1'b0;
        tick();
        chk("v2_busy_hold", {511'b0, busy1}, 512'd1);
        sb_set = 1'b1;
        tick();
        chk("conflict_pulse", {511'b0, sb_conflict}, 512'd1);
        chk("v2_busy_conf", {511'b0, busy1}, 512'd1);
        sb_set = 1'b0;
        tick();
        chk("conflict_drop", {511'b0, sb_conflict}, '0);
        we = 1'b1; wsel_v = 1'b1; wa = 4'd2; wd = bcast(32'h11); wmask = 16'hFFFF;
        tick();
        chk("v2_busy_clr", {511'b0, busy1}, '0);
        chk("v2_data", rd1, bcast(32'h11));
        we = 1'b0;

        // simultaneous set and clear on s6
        we = 1'b1; wsel_v = 1'b0; wa = 4'd6; wd = lane_only(15, 32'h55);
        sb_set = 1'b1; sb_set_v = 1'b0; sb_idx = 4'd6;
        ra1 = 4'd6; rsel1 = 2'b01;
        tick();
        chk("s6_busy", {511'b0, busy1}, 512'd1);
        chk("s6_fwd", rd1, lane_only(15, 32'h55));
        we = 1'b0; sb_set = 1'b0;
        tick();
        chk("s6_busy_hold", {511'b0, busy1}, 512'd1);
        chk("s6_data", rd1, lane_only(15, 32'h55));

        // reset mid-operation
        we = 1'b1; wsel_v = 1'b1; wa = 4'd7; wd = bcast(32'h33); wmask = 16'hFFFF;
        sb_set = 1'b1; sb_set_v = 1'b1; sb_idx = 4'd7;
        rst = 1'b0;
        #1;
        chk("midrst_rd1", rd1, '0);
        chk("midrst_busy1", {511'b0, busy1}, '0);
        tick();
        rst = 1'b1; we = 1'b0; sb_set = 1'b0;
        ra1 = 4'd7; rsel1 = 2'b00; ra2 = 4'd6; rsel2 = 2'b01;
        tick();
        chk("post_v7", rd1, '0);
        chk("post_v7_busy", {511'b0, busy1}, '0);
        chk("post_s6", rd2, '0);
        chk("post_s6_busy", {511'b0, busy2}, '0);
        chk("post_conflict", {511'b0, sb_conflict}, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vec_regfile_v2.md
# vec_regfile_v2

Parametrised vector/scalar register file for the SIMD core datapath, sitting between decode and the execute lanes. It holds `NVREG` vector registers of `LANES` × `W` bits and `NSREG` scalar registers, with the top scalar index aliased to the PC input. Each of its two read ports is registered and can read vector, scalar or scalar-broadcast data, with write-first forwarding. A write port takes per-lane byte-free lane masks, and a per-register busy scoreboard covers multi-cycle (memory) writebacks.

## Interface
- `LANES`, 16: lanes per vector register
- `W`, 32: bits per lane / scalar
- `NVREG`, 16: vector registers
- `NSREG`, 16: scalar registers. Index `NSREG-1` is the PC alias.
- `AW`, `$clog2(max(NVREG,NSREG))`: register index width (derived)
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `pc` in W: value returned for scalar index `NSREG-1`
- `ra1`, `ra2` in AW: read addresses
- `rsel1`, `rsel2` in 2: 00 vector, 01 scalar (top lane only), 10 scalar broadcast, 11 reserved (reads as 0)
- `we` in 1: write enable
- `wsel_v` in 1: 1 selects a vector write, 0 selects a scalar write
- `wa` in AW: write address
- `wd` in LANES×W: write data. A scalar write uses lane `LANES-1`.
- `wmask` in LANES: per-lane write enable for vector writes. Ignored for scalar writes.
- `sb_set` in 1, `sb_set_v` in 1, `sb_idx` in AW: mark a register busy (pending writeback)
- `rd1`, `rd2` out LANES×W: registered read data
- `busy1`, `busy2` out 1: registered busy flag of the register read on each port
- `sb_conflict` out 1: pulses when `sb_set` targets a register that is already busy

## Operation
- Reset, while `rst` is low:
  - all vector and scalar registers are 0
  - all busy bits are 0
  - `rd1`, `rd2` are 0
  - `busy1`, `busy2` and `sb_conflict` are 0
- Vector write (`we & wsel_v`): only the lanes with a set `wmask` bit are updated.
- Scalar write (`we & ~wsel_v`):
  - `sreg[wa]` takes `wd[LANES-1]`.
  - A write to `NSREG-1` (the PC alias) or to an out-of-range index is dropped.
- Vector write with `wa >= NVREG`: dropped.
- Read data per port, by `rsel`:
  - vector: all lanes of `vreg[ra]`
  - scalar: lane `LANES-1` holds `sreg[ra]`, or `pc` when `ra == NSREG-1`; all other lanes are 0
  - broadcast: that scalar value replicated into every lane
- Forwarding (write-first): if the read port matches the write in the same cycle, `rd` shows the new data.
  - Forwarding applies only when the kind matches (vector read with vector write, scalar/broadcast read with scalar write) and the address matches.
  - For vector reads, forwarding is per lane under `wmask`.
- Scoreboard: vector and scalar busy bits are kept separately.
  - `sb_set` sets `busy[sb_set_v][sb_idx]`.
  - Any accepted write (`we`) clears the busy bit of its target.
  - Same register set and cleared in the same cycle: the set wins (new pending op).
  - `sb_set` to an already-busy register: the bit stays 1 and `sb_conflict` is 1 for the next cycle only.
- `busyN` reflects the post-update scoreboard state for the register read in that cycle. The PC alias is never busy.

## Timing
- Read latency is 1 cycle: `ra`/`rsel` sampled at edge N appear on `rd` and `busy` after edge N.
- A write at edge N is visible to a read sampled at edge N through forwarding, and from the register array afterwards.
- `pc` is sampled at the read edge; there is no separate PC pipeline.
- Asserting reset mid-operation clears every output and all state immediately. The first read after reset release returns 0 (or `pc` for the alias index).
- There are no stalls or back-pressure. Every cycle accepts one write, two reads and one scoreboard set.

## Structure
- Package `rf_pkg` holds:
  - the `rsel_t` enum (`RS_VEC`, `RS_SCA`, `RS_BCAST`, `RS_RSVD`)
  - the `lane_t` typedef (`logic [W-1:0]`)
  - the default parameter constants
- One sub-module, `rf_scoreboard`:
  - holds the busy bit vectors and the set/clear priority
  - generates the conflict pulse
  - provides two combinational lookup ports
- The top level holds the arrays, write masking, read muxing and forwarding.

## Test plan
- **Reset contents:** pulse `rst` low, read v3 with `rsel=00` and s2 with `rsel=01` → `rd` all 0 and `busy` 0. Read index 15 with `rsel=01` and `pc=0x100` → lane 15 is `0x100`, other lanes 0.
- **Masked write with forwarding:** write v5 with all lanes `0xA5` and `wmask=0x00FF`, and read v5 in the same cycle → lanes 0-7 are `0xA5`, lanes 8-15 are 0. The same result holds on the next-cycle read.
- **Scalar write and broadcast:** write s4 = 7 (lane 15 of `wd`), then read s4 with `rsel=10` → all 16 lanes are 7. Write s15 = 9, then read s15 → `pc` is returned, not 9.
- **Scoreboard:** `sb_set` on v2 → a read of v2 shows `busy1=1`. A write to v2 → busy clears. A second `sb_set` on v2 while busy → `sb_conflict=1` for one cycle.
- **Simultaneous set and clear:** in the same cycle, write s6 and `sb_set` s6 → s6 stays busy and its data is updated.
- **Reset mid-operation:** assert `rst` while `we=1` and `sb_set=1` → no write lands, and the outputs and scoreboard are 0 on the next read.
